potential_decay_array: RTL

Time-multiplexed leaky-integrate-and-fire (LIF) decay engine for a bank of `NEURON_COUNT` neurons. It holds each neuron's IEEE-754 single-precision membrane potential and a per-neuron decay rate. On each timestep `clear` it sweeps every neuron once, decays the potential by an exponent-domain shift (or ×0.75), and writes the result back. It also streams each decayed value to the spike/threshold stage through a valid/ready handshake. It sits between the potential adder (write side) and the threshold/spike logic (stream side) inside a neuron cluster.

---
 rtl/potential_decay_pkg.sv | 25 ++
 rtl/potential_decay_array_core.sv | 58 +++++
 rtl/potential_decay_array.sv | 112 +++++++++++
 3 files changed

// File: rtl/potential_decay_pkg.sv
// rtl/potential_decay_pkg.sv - rate codes, float field constants and FSM states for the LIF decay engine
package potential_decay_pkg;

    typedef enum logic [2:0] {
        RATE_DIV1   = 3'd0,
        RATE_DIV2   = 3'd1,
        RATE_DIV4   = 3'd2,
        RATE_DIV8   = 3'd3,
        RATE_MUL075 = 3'd4
    } rate_e;

    localparam int         SIGN_BIT = 31;
    localparam int         EXP_MSB  = 30;
    localparam int         EXP_LSB  = 23;
    localparam int         MAN_MSB  = 22;
    localparam logic [7:0] EXP_MAX  = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/potential_decay_array_core.sv
// rtl/potential_decay_array_core.sv - combinational fp32 decay (shift / x0.75 / flush / Inf-NaN)
// Optional x0.75 datapath built only with POTENTIAL_DECAY_THREEQUARTER_EN.
module fp_decay_core
    import potential_decay_pkg::*;
(
    input  logic [31:0] i_operand,
    input  logic [2:0]  i_rate,
    output logic [31:0] o_result,
    output logic        o_exc
);

    logic [7:0]  w_exp;
    logic [7:0]  w_k;
    logic [22:0] w_man_n;

    assign w_exp = i_operand[EXP_MSB:EXP_LSB];

`ifdef POTENTIAL_DECAY_THREEQUARTER_EN
    logic [25:0] w_t;
    // 3*s with s = {1, mantissa}; the product lands in [2^24, 2^25 + 2^24)
    assign w_t = {2'b00, 1'b1, i_operand[MAN_MSB:0]} * 26'd3;
`endif

    always_comb begin
        w_k     = 8'd0;
        w_man_n = i_operand[MAN_MSB:0];
        case (i_rate)
            RATE_DIV2: w_k = 8'd1;
            RATE_DIV4: w_k = 8'd2;
            RATE_DIV8: w_k = 8'd3;
`ifdef POTENTIAL_DECAY_THREEQUARTER_EN
            RATE_MUL075: begin
                if (w_t[25]) begin
                    w_man_n = w_t[24:2];
                end else begin
                    w_k     = 8'd1;
                    w_man_n = w_t[23:1];
                end
            end
`endif
            default: w_k = 8'd0;
        endcase
    end

    always_comb begin
        o_exc    = 1'b0;
        o_result = {i_operand[SIGN_BIT], w_exp - w_k, w_man_n};
        if (w_exp == 8'd0) begin
            o_result = 32'h0;
        end else if (w_exp == EXP_MAX) begin
            o_result = i_operand;
            o_exc    = 1'b1;
        end else if (w_exp <= w_k) begin
            o_result = 32'h0;
        end
    end

endmodule

// File: rtl/potential_decay_array.sv
// rtl/potential_decay_array.sv - time-multiplexed LIF potential decay sweep with streamed results
// Build option: POTENTIAL_DECAY_THREEQUARTER_EN enables rate code 4 (x0.75) in fp_decay_core.
module potential_decay_array
    import potential_decay_pkg::*;
#(
    parameter int NEURON_COUNT = 16,
    parameter int ADDR_W       = $clog2(NEURON_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [2:0]        cfg_rate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              busy,
    output logic              done,
    output logic              exc_flag,
    output logic              overrun
);

    logic [31:0]       r_pot  [NEURON_COUNT];
    logic [2:0]        r_rate [NEURON_COUNT];
    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_issue_addr;
    logic              r_clear_d;
    logic              w_rise;
    logic              w_issue;
    logic              w_last;
    logic [31:0]       w_result;
    logic              w_exc;

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign wr_ready = !busy;
    assign w_rise   = clear && !r_clear_d;
    assign w_last   = (r_issue_addr == ADDR_W'(NEURON_COUNT - 1));
    // Issue only when the single output register is free or being drained this cycle
    assign w_issue  = (r_state == ST_SWEEP) && (!out_valid || out_ready);

    fp_decay_core u_core (
        .i_operand (r_pot[r_issue_addr]),
        .i_rate    (r_rate[r_issue_addr]),
        .o_result  (w_result),
        .o_exc     (w_exc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_rise) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_issue && w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_ready) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Host writes are only accepted while idle, so they never race the write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURON_COUNT; i++) begin
                r_pot[i]  <= 32'h0;
                r_rate[i] <= 3'd1;
            end
        end else begin
            if (wr_valid && !busy) r_pot[wr_addr] <= wr_data;
            if (cfg_we && !busy)   r_rate[cfg_addr] <= cfg_rate;
            if (w_issue)           r_pot[r_issue_addr] <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_clear_d     <= 1'b0;
            r_issue_addr  <= '0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= 32'h0;
            exc_flag      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clear_d <= clear;
            if (w_rise && busy) overrun <= 1'b1;
            if (r_state == ST_IDLE && w_rise) begin
                r_issue_addr <= '0;
                exc_flag     <= 1'b0;
            end else if (w_issue) begin
                if (!w_last) r_issue_addr <= r_issue_addr + 1'b1;
                if (w_exc)   exc_flag     <= 1'b1;
            end
            if (w_issue) begin
                out_valid     <= 1'b1;
                out_addr      <= r_issue_addr;
                out_potential <= w_result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
